// File: rtl/angle_scorer_if.sv
// Handshake and result bundle between a reference-angle source and angle_scorer.
// ANGLE_SCORER_MAX_ERR_EN adds the max_err/max_idx result fields.
interface angle_scorer_if #(
  parameter int ANGLE_DEPTH = 10,
  parameter int NUM_JOINTS  = 3,
  parameter int SCORE_W     = 10
);
  localparam int IDX_W = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;

  logic                   start;
  logic                   in_valid;
  logic [ANGLE_DEPTH-1:0] ref_angle;
  logic [ANGLE_DEPTH-1:0] meas_angle;
  logic                   busy;
  logic [SCORE_W-1:0]     score;
  logic                   score_valid;
  logic [NUM_JOINTS-1:0]  match_mask;
  logic                   all_match;
`ifdef ANGLE_SCORER_MAX_ERR_EN
  logic [ANGLE_DEPTH-1:0] max_err;
  logic [IDX_W-1:0]       max_idx;

  modport master (
    output start, in_valid, ref_angle, meas_angle,
    input  busy, score, score_valid, match_mask, all_match, max_err, max_idx
  );
  modport slave (
    input  start, in_valid, ref_angle, meas_angle,
    output busy, score, score_valid, match_mask, all_match, max_err, max_idx
  );
`else
  modport master (
    output start, in_valid, ref_angle, meas_angle,
    input  busy, score, score_valid, match_mask, all_match
  );
  modport slave (
    input  start, in_valid, ref_angle, meas_angle,
    output busy, score, score_valid, match_mask, all_match
  );
`endif
endinterface

// File: rtl/angle_scorer.sv
// Wrap-aware per-joint angle error, tolerance flags and saturating frame score.
// Define ANGLE_SCORER_MAX_ERR_EN to also report the worst joint error and its index.
module angle_scorer #(
  parameter int ANGLE_DEPTH = 10,
  parameter int NUM_JOINTS  = 3,
  parameter int SCORE_W     = 10,
  parameter int TOL         = 32
) (
  input logic          clk,
  input logic          rst_n,
  angle_scorer_if.slave bus
);
  localparam int IDX_W = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;
  localparam int SUM_W = ((SCORE_W > ANGLE_DEPTH) ? SCORE_W : ANGLE_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, REPORT} state_t;

  // Shortest distance around the circle between two angle codes.
  function automatic logic [ANGLE_DEPTH-1:0] ang_err(input logic [ANGLE_DEPTH-1:0] a,
                                                     input logic [ANGLE_DEPTH-1:0] b);
    logic [ANGLE_DEPTH-1:0] d;
    logic [ANGLE_DEPTH-1:0] nd;
    d  = a - b;
    nd = '0 - d;
    return (d < nd) ? d : nd;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0]     acc,
                                                 input logic [ANGLE_DEPTH-1:0] e);
    logic [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(e);
    if ((s >> SCORE_W) != '0) return '1;
    return s[SCORE_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q;
  logic             flush_q;
  logic             accept;
  logic             last_accept;

  assign accept      = (state_q == ACCUM) && bus.in_valid;
  assign last_accept = accept && (cnt_q == IDX_W'(NUM_JOINTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ACCUM;
      ACCUM:   if (last_accept) state_d = FLUSH;
      FLUSH:   if (flush_q) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start) cnt_q <= '0;
      else if (accept)                  cnt_q <= cnt_q + 1'b1;
      flush_q <= (state_q == FLUSH) ? ~flush_q : 1'b0;
    end
  end

  // ---- stage 1: per-joint error ----
  logic [ANGLE_DEPTH-1:0] err_p1;
  logic [IDX_W-1:0]       idx_p1;
  logic                   vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      err_p1 <= ang_err(bus.ref_angle, bus.meas_angle);
      idx_p1 <= cnt_q;
    end
  end

  // ---- stage 2: frame accumulation ----
  logic [SCORE_W-1:0]     acc_p2;
  logic [NUM_JOINTS-1:0]  match_p2;
  logic [ANGLE_DEPTH-1:0] max_err_p2;
  logic [IDX_W-1:0]       max_idx_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2     <= '0;
      match_p2   <= '0;
      max_err_p2 <= '0;
      max_idx_p2 <= '0;
    end else if (state_q == IDLE && bus.start) begin
      acc_p2     <= '0;
      match_p2   <= '0;
      max_err_p2 <= '0;
      max_idx_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= sat_add(acc_p2, err_p1);
      for (int i = 0; i < NUM_JOINTS; i++)
        if (idx_p1 == IDX_W'(i)) match_p2[i] <= (err_p1 <= ANGLE_DEPTH'(TOL));
      // Strict compare keeps the earliest joint on ties.
      if (err_p1 > max_err_p2) begin
        max_err_p2 <= err_p1;
        max_idx_p2 <= idx_p1;
      end
    end
  end

  // ---- report registers ----
  logic [SCORE_W-1:0]     score_q;
  logic                   score_valid_q;
  logic [NUM_JOINTS-1:0]  match_q;
  logic                   all_match_q;
  logic [ANGLE_DEPTH-1:0] max_err_q;
  logic [IDX_W-1:0]       max_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q       <= '0;
      score_valid_q <= 1'b0;
      match_q       <= '0;
      all_match_q   <= 1'b0;
      max_err_q     <= '0;
      max_idx_q     <= '0;
    end else begin
      score_valid_q <= (state_q == REPORT);
      if (state_q == REPORT) begin
        score_q     <= acc_p2;
        match_q     <= match_p2;
        all_match_q <= &match_p2;
        max_err_q   <= max_err_p2;
        max_idx_q   <= max_idx_p2;
      end
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.score       = score_q;
  assign bus.score_valid = score_valid_q;
  assign bus.match_mask  = match_q;
  assign bus.all_match   = all_match_q;
`ifdef ANGLE_SCORER_MAX_ERR_EN
  assign bus.max_err     = max_err_q;
  assign bus.max_idx     = max_idx_q;
`else
  logic unused_max;
  assign unused_max = ^{max_err_q, max_idx_q};
`endif
endmodule

// File: tb/tb_angle_scorer.sv
// Randomized self-checking bench for angle_scorer against a frame-level arithmetic model.
module tb_angle_scorer;
  localparam int AD   = 10;
  localparam int NJ   = 3;
  localparam int SW   = 10;
  localparam int TOL  = 32;
  localparam int FULL = 1 << AD;
  localparam int SMAX = (1 << SW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  angle_scorer_if #(.ANGLE_DEPTH(AD), .NUM_JOINTS(NJ), .SCORE_W(SW)) bus ();
  angle_scorer #(.ANGLE_DEPTH(AD), .NUM_JOINTS(NJ), .SCORE_W(SW), .TOL(TOL))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_mis = 0;
  int sv_count = 0;
  int fr_ref [NJ];
  int fr_meas[NJ];

  always @(negedge clk) if (bus.score_valid === 1'b1) sv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_err(input int r, input int m);
    int d;
    d = (((r - m) % FULL) + FULL) % FULL;
    return (d < FULL - d) ? d : FULL - d;
  endfunction

  // Drives one frame from fr_ref/fr_meas; poke adds protocol noise that must be ignored.
  task automatic run_frame(input string tag, input int max_bub, input bit poke);
    int sum, mask, mx, mi, e, sv0, n, bub;
    sum = 0; mask = 0; mx = 0; mi = 0;
    for (int j = 0; j < NJ; j++) begin
      e = ref_err(fr_ref[j], fr_meas[j]);
      sum += e;
      if (e <= TOL) mask |= (1 << j);
      if (e > mx) begin mx = e; mi = j; end
    end
    if (sum > SMAX) sum = SMAX;
    sv0 = sv_count;

    @(posedge clk); #1;
    bus.start = 1'b1;
    if (poke) begin
      bus.in_valid   = 1'b1;
      bus.ref_angle  = AD'($urandom);
      bus.meas_angle = AD'($urandom);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".busy_accum"}, 32'(bus.busy), 1);
    @(posedge clk); #1;

    for (int j = 0; j < NJ; j++) begin
      bub = (max_bub > 0) ? int'($urandom_range(max_bub, 0)) : 0;
      repeat (bub) begin
        bus.in_valid = 1'b0;
        if (poke && $urandom_range(1, 0) == 1) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      bus.in_valid   = 1'b1;
      bus.ref_angle  = AD'(fr_ref[j]);
      bus.meas_angle = AD'(fr_meas[j]);
      if (poke) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
    end
    if (poke) begin
      bus.in_valid   = 1'b1;
      bus.ref_angle  = AD'($urandom);
      bus.meas_angle = AD'($urandom);
    end

    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n = k;
      if (k == 2) bus.in_valid = 1'b0;
      if (k == 3) check({tag, ".busy_report"}, 32'(bus.busy), 1);
      if (bus.score_valid === 1'b1) break;
      n = 11;
    end
    check({tag, ".latency"}, n, 4);
    check({tag, ".score"}, 32'(bus.score), sum);
    check({tag, ".mask"}, 32'(bus.match_mask), mask);
    check({tag, ".all_match"}, 32'(bus.all_match), (mask == (1 << NJ) - 1) ? 1 : 0);
    check({tag, ".busy_done"}, 32'(bus.busy), 0);
`ifdef ANGLE_SCORER_MAX_ERR_EN
    check({tag, ".max_err"}, 32'(bus.max_err), mx);
    check({tag, ".max_idx"}, 32'(bus.max_idx), mi);
`endif
    repeat (3) @(negedge clk);
    check({tag, ".pulses"}, sv_count - sv0, 1);
    check({tag, ".hold"}, 32'(bus.score), sum);
  endtask

  task automatic set_frame(input int r0, m0, r1, m1, r2, m2);
    fr_ref[0] = r0; fr_meas[0] = m0;
    fr_ref[1] = r1; fr_meas[1] = m1;
    fr_ref[2] = r2; fr_meas[2] = m2;
  endtask

  initial begin
    int sv0;
    bus.start = 1'b0; bus.in_valid = 1'b0;
    bus.ref_angle = '0; bus.meas_angle = '0;
    #1;
    check("reset.score", 32'(bus.score), 0);
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.valid", 32'(bus.score_valid), 0);
    check("reset.mask", 32'(bus.match_mask), 0);
    check("reset.all", 32'(bus.all_match), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    set_frame(100, 100, 200, 210, 300, 290);
    run_frame("basic", 0, 0);
    set_frame(1020, 5, 0, 512, 40, 0);
    run_frame("wrap", 0, 0);
    set_frame(0, 512, 0, 512, 0, 512);
    run_frame("sat", 0, 0);
    set_frame(100, 100, 200, 210, 300, 290);
    run_frame("bubble", 3, 1);

    // Abort a frame after two accepted pairs.
    sv0 = sv_count;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bus.in_valid = 1'b1; bus.ref_angle = AD'(10 * j); bus.meas_angle = AD'(500);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(bus.busy), 0);
    check("abort.score", 32'(bus.score), 0);
    check("abort.mask", 32'(bus.match_mask), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort.no_pulse", sv_count - sv0, 0);
    set_frame(5, 5, 6, 6, 7, 7);
    run_frame("after_abort", 0, 0);

    for (int f = 0; f < 20; f++) begin
      for (int j = 0; j < NJ; j++) begin
        fr_ref[j] = int'($urandom_range(FULL - 1, 0));
        if ($urandom_range(1, 0) == 1)
          fr_meas[j] = (fr_ref[j] + int'($urandom_range(80, 0)) - 40 + FULL) % FULL;
        else
          fr_meas[j] = int'($urandom_range(FULL - 1, 0));
      end
      run_frame($sformatf("rand%0d", f), f % 4, f[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
